// File: rtl/fifo_converter_64to32b_if.sv
// Source/destination FIFO bundle for fifo_converter_64to32b.
//
// The converter pops a 64-bit first-word-fall-through source FIFO. It pushes
// 32-bit halves into a destination FIFO.
//   src_empty : source FIFO empty (src_data valid while low)
//   src_data  : 64-bit source head word
//   src_re    : source FIFO pop
//   dst_full  : destination almost-full (>= 2 free entries while low)
//   dst_we    : destination write enable
//   dst_data  : 32-bit destination write data
// The master modport is the converter side. The slave modport is the FIFO side.
interface fifo_converter_64to32b_if;
  logic        src_empty;
  logic [63:0] src_data;
  logic        src_re;
  logic        dst_full;
  logic        dst_we;
  logic [31:0] dst_data;

  modport master (
    input  src_empty,
    input  src_data,
    input  dst_full,
    output src_re,
    output dst_we,
    output dst_data
  );

  modport slave (
    output src_empty,
    output src_data,
    output dst_full,
    input  src_re,
    input  dst_we,
    input  dst_data
  );
endinterface

// File: rtl/fifo_converter_64to32b.sv
// 64-bit to 32-bit FIFO width converter.
//
// The converter pops one 64-bit word from a FWFT source FIFO. It then writes
// the word as two 32-bit halves into a destination FIFO, on back-to-back
// cycles. A continuous stream writes one half per cycle.
//
// Ports:
//   digiclk_i  : clock
//   resetn_i   : asynchronous active-low reset
//   start      : one-cycle pulse that begins a transfer (ignored while busy)
//   xfer_len   : transfer length in 64-bit words, latched on start
//   abort      : level; stops the transfer at the next word boundary
//   bus        : source/destination FIFO signals (master modport)
//   busy       : transfer in progress
//   done       : one-cycle pulse on normal completion, with the last write
//   words_left : 64-bit words not yet popped
//
// Build option: define CONV_HIGH_FIRST_EN to write hold[63:32] first.
// By default hold[31:0] is written first. Timing is the same either way.
module fifo_converter_64to32b (
  input  logic                             digiclk_i,
  input  logic                             resetn_i,
  input  logic                             start,
  input  logic [15:0]                      xfer_len,
  input  logic                             abort,
  fifo_converter_64to32b_if.master         bus,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      words_left
);

  // StIdle / StSendA / StSendB correspond to IDLE / SEND_A / SEND_B.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSendA = 2'd1,
    StSendB = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] hold_q, hold_d;
  logic        src_re_q, src_re_d;
  logic        dst_we_q, dst_we_d;
  logic [31:0] dst_data_q, dst_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] words_left_q, words_left_d;

  logic        go;
  logic        capture;
  logic [31:0] first_half;
  logic [31:0] second_half;

`ifdef CONV_HIGH_FIRST_EN
  assign first_half  = hold_q[63:32];
  assign second_half = hold_q[31:0];
`else
  assign first_half  = hold_q[31:0];
  assign second_half = hold_q[63:32];
`endif

  // The source and destination FIFOs are looked at only in StIdle and StSendB.
  // A word that has been captured is therefore always written out in full.
  // dst_full low guarantees room for both halves.
  assign go = busy_q & (words_left_q != 16'd0) & ~bus.src_empty & ~bus.dst_full & ~abort;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    src_re_d     = 1'b0;
    dst_we_d     = 1'b0;
    dst_data_d   = dst_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    words_left_d = words_left_q;
    capture      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (busy_q && abort) begin
          busy_d       = 1'b0;
          words_left_d = 16'd0;
        end else if (go) begin
          capture = 1'b1;
          state_d = StSendA;
        end else if (!busy_q && start && !abort) begin
          // A zero-length start only clears words_left. It never raises busy.
          words_left_d = xfer_len;
          busy_d       = (xfer_len != 16'd0);
        end
      end

      StSendA: begin
        dst_we_d   = 1'b1;
        dst_data_d = first_half;
        state_d    = StSendB;
      end

      StSendB: begin
        dst_we_d   = 1'b1;
        dst_data_d = second_half;
        if (busy_q && abort) begin
          busy_d       = 1'b0;
          words_left_d = 16'd0;
          state_d      = StIdle;
        end else if (go) begin
          capture = 1'b1;
          state_d = StSendA;
        end else begin
          state_d = StIdle;
          // done is registered here so that it lands on the final second-half write.
          if (busy_q && (words_left_q == 16'd0)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // go implies words_left != 0, so the decrement cannot wrap.
    // go also implies src_empty == 0, so src_re never pops an empty FIFO.
    if (capture) begin
      hold_d       = bus.src_data;
      src_re_d     = 1'b1;
      words_left_d = words_left_q - 16'd1;
    end
  end

  always_ff @(posedge digiclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= StIdle;
      hold_q       <= 64'h0;
      src_re_q     <= 1'b0;
      dst_we_q     <= 1'b0;
      dst_data_q   <= 32'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      words_left_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      src_re_q     <= src_re_d;
      dst_we_q     <= dst_we_d;
      dst_data_q   <= dst_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      words_left_q <= words_left_d;
    end
  end

  assign bus.src_re   = src_re_q;
  assign bus.dst_we   = dst_we_q;
  assign bus.dst_data = dst_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign words_left   = words_left_q;

endmodule

// File: tb/tb_fifo_converter_64to32b.sv
module tb_fifo_converter_64to32b;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] xfer_len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] words_left;

  fifo_converter_64to32b_if bus ();

  fifo_converter_64to32b dut (
    .digiclk_i  (clk),
    .resetn_i   (resetn),
    .start      (start),
    .xfer_len   (xfer_len),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .words_left (words_left)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          we_cnt   = 0;
  int          re_cnt   = 0;
  int          first_we = -1;
  int          last_we  = -1;
  int          start_cyc = 0;
  logic [63:0] src_fifo[$];
  logic [32:0] exp_q[$];   // {done, dst_data} per expected write

  function automatic logic [31:0] half_lo_first(input logic [63:0] w, input bit second);
`ifdef CONV_HIGH_FIRST_EN
    return second ? w[31:0] : w[63:32];
`else
    return second ? w[63:32] : w[31:0];
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic src_update();
    bus.src_empty = (src_fifo.size() == 0);
    bus.src_data  = (src_fifo.size() != 0) ? src_fifo[0] : 64'h0;
  endtask

  task automatic load_src(input logic [63:0] w);
    src_fifo.push_back(w);
    src_update();
  endtask

  task automatic expect_word(input logic [63:0] w, input bit last);
    exp_q.push_back({1'b0, half_lo_first(w, 1'b0)});
    exp_q.push_back({last, half_lo_first(w, 1'b1)});
  endtask

  task automatic clear_counts();
    we_cnt   = 0;
    re_cnt   = 0;
    first_we = -1;
    last_we  = -1;
  endtask

  // One clock cycle: observe at the falling edge; the FWFT source pops on src_re.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.dst_we) begin
      we_cnt++;
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
    end
    if (bus.src_re) begin
      re_cnt++;
      chk("src_re_while_empty", 64'(bus.src_empty), 64'(0));
      if (src_fifo.size() != 0) void'(src_fifo.pop_front());
      src_update();
    end
  endtask

  task automatic do_start(input logic [15:0] len);
    start    = 1'b1;
    xfer_len = len;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    chk("wait_idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic flush_src();
    src_fifo.delete();
    src_update();
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT writes.
  task automatic monitor();
    logic [31:0] last_data = 32'h0;
    logic        rst_prev  = 1'b0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resetn && rst_prev) begin
        if (bus.dst_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(bus.dst_we), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("dst_write_done_data", 64'({done, bus.dst_data}), 64'(e));
          end
        end else begin
          chk("idle_done_hold", 64'({done, bus.dst_data}), 64'({1'b0, last_data}));
        end
      end
      last_data = bus.dst_data;
      rst_prev  = resetn;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    resetn       = 1'b0;
    start        = 1'b0;
    xfer_len     = 16'd0;
    abort        = 1'b0;
    bus.dst_full = 1'b0;
    src_update();
    tick();
    tick();
    chk("reset_outputs",
        64'({bus.src_re, bus.dst_we, bus.dst_data, busy, done, words_left}), 64'(0));
    resetn = 1'b1;
    tick();

    // Streaming, three words.
    clear_counts();
    load_src(64'h1111_1111_0000_0000);
    load_src(64'h3333_3333_2222_2222);
    load_src(64'h5555_5555_4444_4444);
    expect_word(64'h1111_1111_0000_0000, 1'b0);
    expect_word(64'h3333_3333_2222_2222, 1'b0);
    expect_word(64'h5555_5555_4444_4444, 1'b1);
    do_start(16'd3);
    chk("stream_busy_after_start", 64'(busy), 64'(1));
    chk("stream_words_left_latched", 64'(words_left), 64'(3));
    wait_idle(40);
    chk("stream_writes", 64'(we_cnt), 64'(6));
    chk("stream_pops", 64'(re_cnt), 64'(3));
    chk("stream_first_write_latency", 64'(first_we - start_cyc), 64'(2));
    chk("stream_back_to_back", 64'(last_we - first_we + 1), 64'(6));
    chk("stream_words_left_end", 64'(words_left), 64'(0));
    tick();

    // Backpressure during SEND_A of word 1 of 2.
    clear_counts();
    load_src(64'hBBBB_BBBB_AAAA_AAAA);
    load_src(64'hDDDD_DDDD_CCCC_CCCC);
    expect_word(64'hBBBB_BBBB_AAAA_AAAA, 1'b0);
    expect_word(64'hDDDD_DDDD_CCCC_CCCC, 1'b1);
    do_start(16'd2);
    tick();
    bus.dst_full = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_writes_stalled", 64'(we_cnt), 64'(2));
    chk("bp_words_left", 64'(words_left), 64'(1));
    chk("bp_busy", 64'(busy), 64'(1));
    chk("bp_pops_stalled", 64'(re_cnt), 64'(1));
    bus.dst_full = 1'b0;
    wait_idle(20);
    chk("bp_writes_total", 64'(we_cnt), 64'(4));
    chk("bp_pops_total", 64'(re_cnt), 64'(2));
    tick();

    // Underflow: four requested, two available.
    clear_counts();
    load_src(64'h0000_0002_0000_0001);
    load_src(64'h0000_0004_0000_0003);
    expect_word(64'h0000_0002_0000_0001, 1'b0);
    expect_word(64'h0000_0004_0000_0003, 1'b0);
    do_start(16'd4);
    for (int i = 0; i < 15; i++) tick();
    chk("uf_writes", 64'(we_cnt), 64'(4));
    chk("uf_busy", 64'(busy), 64'(1));
    chk("uf_words_left", 64'(words_left), 64'(2));
    chk("uf_pops", 64'(re_cnt), 64'(2));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("uf_abort_idle_busy", 64'(busy), 64'(0));
    chk("uf_abort_idle_words_left", 64'(words_left), 64'(0));

    // Abort during SEND_A of word 2 of 5.
    clear_counts();
    load_src(64'h1000_0001_1000_0000);
    load_src(64'h2000_0001_2000_0000);
    load_src(64'h3000_0001_3000_0000);
    load_src(64'h4000_0001_4000_0000);
    load_src(64'h5000_0001_5000_0000);
    expect_word(64'h1000_0001_1000_0000, 1'b0);
    expect_word(64'h2000_0001_2000_0000, 1'b0);
    do_start(16'd5);
    tick();
    tick();
    tick();
    abort = 1'b1;
    wait_idle(20);
    tick();
    abort = 1'b0;
    chk("abort_writes", 64'(we_cnt), 64'(4));
    chk("abort_pops", 64'(re_cnt), 64'(2));
    chk("abort_words_left", 64'(words_left), 64'(0));
    flush_src();

    // Start and abort together: abort wins.
    start    = 1'b1;
    abort    = 1'b1;
    xfer_len = 16'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    chk("start_abort_busy", 64'(busy), 64'(0));
    chk("start_abort_words_left", 64'(words_left), 64'(0));

    // Reset in SEND_A: the held word is discarded.
    clear_counts();
    load_src(64'h7777_7777_6666_6666);
    load_src(64'h9999_9999_8888_8888);
    do_start(16'd2);
    tick();
    resetn = 1'b0;
    #1;
    chk("midword_reset_outputs",
        64'({bus.src_re, bus.dst_we, bus.dst_data, busy, done, words_left}), 64'(0));
    tick();
    tick();
    resetn = 1'b1;
    flush_src();
    for (int i = 0; i < 4; i++) tick();
    chk("midword_reset_no_writes", 64'(we_cnt), 64'(0));
    do_start(16'd0);
    tick();
    chk("zero_len_busy", 64'(busy), 64'(0));
    chk("zero_len_words_left", 64'(words_left), 64'(0));

    tick();
    chk("all_expected_writes_seen", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
